// File: rtl/mips_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_core_pkg
// Shared types and constants for the load value-prediction block.
//   vp_state_e  : controller FSM states
//   vp_entry_t  : one last-value table entry as seen on the table read port
//   VP_CONF_MAX : saturation value of the 2-bit confidence counter
// -----------------------------------------------------------------------------
package mips_core_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  // Widest partial tag a table instance may be configured with; narrower
  // tags are zero-extended into vp_entry_t.tag.
  localparam int VP_TAG_MAX_W = 16;

  localparam logic [1:0] VP_CONF_MAX = 2'd3;

  typedef enum logic [1:0] {
    VP_IDLE    = 2'd0,
    VP_WAIT    = 2'd1,  // unpredicted miss pending
    VP_SPEC    = 2'd2,  // prediction issued, awaiting verification
    VP_RECOVER = 2'd3   // mispredict, waiting for front-end ack
  } vp_state_e;

  typedef struct packed {
    logic                    valid;
    logic [VP_TAG_MAX_W-1:0] tag;
    logic [DATA_WIDTH-1:0]   value;
    logic [1:0]              conf;
  } vp_entry_t;

  // Saturating confidence increment.
  function automatic logic [1:0] conf_sat_inc(input logic [1:0] conf);
    return (conf == VP_CONF_MAX) ? VP_CONF_MAX : conf + 2'd1;
  endfunction

endpackage

// File: rtl/vp_table.sv
// -----------------------------------------------------------------------------
// vp_table
// Direct-mapped last-value table with 2-bit confidence.
//   Read port  : rd_pc -> rd_entry (combinational)
//   Train port : train_en/train_pc/train_data (registered write)
//     hit & equal   -> conf saturating increment
//     hit & unequal -> value replaced, conf = 0
//     miss          -> allocate tag/value, conf = 0, valid = 1
// Ports: clk, rst_n (async active-low), rd_pc, rd_entry, train_en,
//        train_pc, train_data.
// -----------------------------------------------------------------------------
module vp_table
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_pc,
  output vp_entry_t             rd_entry,
  input  logic                  train_en,
  input  logic [ADDR_WIDTH-1:0] train_pc,
  input  logic [DATA_WIDTH-1:0] train_data
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LO  = INDEX_WIDTH + 2;
  localparam int TAG_HI  = INDEX_WIDTH + TAG_WIDTH + 1;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] value_q [ENTRIES];
  logic [1:0]            conf_q  [ENTRIES];

  logic [INDEX_WIDTH-1:0] rd_idx, tr_idx;
  logic [TAG_WIDTH-1:0]   tr_tag;
  logic                   tr_hit, tr_equal;

  // PC bits outside the index/tag fields are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[ADDR_WIDTH-1:TAG_LO], rd_pc[1:0],
                            train_pc[ADDR_WIDTH-1:TAG_HI+1], train_pc[1:0]};

  // ---------------- read port ----------------
  assign rd_idx = rd_pc[INDEX_WIDTH+1:2];

  always_comb begin
    rd_entry       = '0;
    rd_entry.valid = valid_q[rd_idx];
    rd_entry.tag   = VP_TAG_MAX_W'(tag_q[rd_idx]);
    rd_entry.value = value_q[rd_idx];
    rd_entry.conf  = conf_q[rd_idx];
  end

  // ---------------- train port ----------------
  assign tr_idx   = train_pc[INDEX_WIDTH+1:2];
  assign tr_tag   = train_pc[TAG_HI:TAG_LO];
  assign tr_hit   = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);
  assign tr_equal = (value_q[tr_idx] == train_data);

  // Control state (valid, confidence) is reset so a cold table never
  // predicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) conf_q[i] <= 2'd0;
    end else if (train_en) begin
      valid_q[tr_idx] <= 1'b1;
      if (tr_hit && tr_equal) conf_q[tr_idx] <= conf_sat_inc(conf_q[tr_idx]);
      else                    conf_q[tr_idx] <= 2'd0;
    end
  end

  // NOTE: tag/value storage carries no reset; an entry is only read as a
  // hit once its valid bit is set, so resetting the data array would add
  // fan-out to rst_n without changing behaviour.
  always_ff @(posedge clk) begin
    if (train_en) begin
      if (!tr_hit)              tag_q[tr_idx]   <= tr_tag;
      if (!(tr_hit && tr_equal)) value_q[tr_idx] <= train_data;
    end
  end

endmodule

// File: rtl/vp_controller.sv
// -----------------------------------------------------------------------------
// vp_controller
// MEM-stage load value-prediction sequencer. On a D-cache miss it looks the
// load up in the last-value table and, if confident, issues a predicted value
// and locks younger memory ops until the fill verifies it. A mismatch raises
// a recovery request that is held until the front end acknowledges.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   vp_allow            global prediction enable (table trains regardless)
//   ld_miss, ld_pc      load miss pulse and its PC
//   dc_resp_valid/data  D-cache fill
//   squash              older-instruction flush, kills the outstanding load
//   recover_ack         front end has redirected
//   pred_valid/data     predicted value (one-cycle pulse)
//   spec_lock           blocks younger loads/stores
//   recover_req/pc      recovery handshake (level until ack)
//   commit              prediction verified correct (one-cycle pulse)
//
// Optional: define VP_STATS_EN to add 32-bit wrap-around counters
//   stat_pred, stat_correct, stat_recover.
// -----------------------------------------------------------------------------
module vp_controller
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int CONF_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_allow,
  input  logic                  ld_miss,
  input  logic [ADDR_WIDTH-1:0] ld_pc,
  input  logic                  dc_resp_valid,
  input  logic [DATA_WIDTH-1:0] dc_resp_data,
  input  logic                  squash,
  input  logic                  recover_ack,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_data,
  output logic                  spec_lock,
  output logic                  recover_req,
  output logic [ADDR_WIDTH-1:0] recover_pc,
  output logic                  commit
`ifdef VP_STATS_EN
  ,
  output logic [31:0]           stat_pred,
  output logic [31:0]           stat_correct,
  output logic [31:0]           stat_recover
`endif
);

  localparam logic [1:0] CONF_THR = 2'(CONF_THRESH);
  localparam int         TAG_LO   = INDEX_WIDTH + 2;
  localparam int         TAG_HI   = INDEX_WIDTH + TAG_WIDTH + 1;

  vp_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  pred_valid_q, pred_valid_d;
  logic [DATA_WIDTH-1:0] pred_data_q, pred_data_d;
  logic                  spec_lock_q, spec_lock_d;
  logic                  recover_req_q, recover_req_d;
  logic [ADDR_WIDTH-1:0] recover_pc_q, recover_pc_d;
  logic                  commit_q, commit_d;

  vp_entry_t             rd_entry;
  logic                  rd_hit;
  logic                  train_en;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{ld_pc[ADDR_WIDTH-1:TAG_HI+1], ld_pc[TAG_LO-1:0]};

  vp_table #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pc      (ld_pc),
    .rd_entry   (rd_entry),
    .train_en   (train_en),
    .train_pc   (pend_pc_q),
    .train_data (dc_resp_data)
  );

  assign rd_hit = rd_entry.valid &&
                  (rd_entry.tag == VP_TAG_MAX_W'(ld_pc[TAG_HI:TAG_LO]));

  // ---------------- next-state / output logic ----------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d       = state_q;
    pend_pc_d     = pend_pc_q;
    pred_valid_d  = 1'b0;
    pred_data_d   = pred_data_q;
    spec_lock_d   = spec_lock_q;
    recover_req_d = recover_req_q;
    recover_pc_d  = recover_pc_q;
    commit_d      = 1'b0;
    train_en      = 1'b0;

    unique case (state_q)
      VP_IDLE: begin
        // A response arriving with no miss outstanding is dropped.
        if (ld_miss) begin
          pend_pc_d = ld_pc;
          if (vp_allow && rd_hit && (rd_entry.conf >= CONF_THR)) begin
            pred_valid_d = 1'b1;
            pred_data_d  = rd_entry.value;
            spec_lock_d  = 1'b1;
            state_d      = VP_SPEC;
          end else begin
            state_d = VP_WAIT;
          end
        end
      end

      VP_WAIT: begin
        // squash beats a coincident response: the load is dead, no training.
        if (squash) begin
          state_d = VP_IDLE;
        end else if (dc_resp_valid) begin
          train_en = 1'b1;
          state_d  = VP_IDLE;
        end
      end

      VP_SPEC: begin
        // vp_allow is deliberately not consulted: an issued prediction is
        // always verified.
        if (squash) begin
          spec_lock_d = 1'b0;
          state_d     = VP_IDLE;
        end else if (dc_resp_valid) begin
          train_en = 1'b1;
          if (dc_resp_data == pred_data_q) begin
            commit_d    = 1'b1;
            spec_lock_d = 1'b0;
            state_d     = VP_IDLE;
          end else begin
            recover_req_d = 1'b1;
            recover_pc_d  = pend_pc_q;
            state_d       = VP_RECOVER;
          end
        end
      end

      VP_RECOVER: begin
        // squash is ignored here: the redirect must complete.
        if (recover_ack) begin
          recover_req_d = 1'b0;
          spec_lock_d   = 1'b0;
          state_d       = VP_IDLE;
        end
      end

      default: state_d = VP_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= VP_IDLE;
      pend_pc_q     <= '0;
      pred_valid_q  <= 1'b0;
      pred_data_q   <= '0;
      spec_lock_q   <= 1'b0;
      recover_req_q <= 1'b0;
      recover_pc_q  <= '0;
      commit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      pred_valid_q  <= pred_valid_d;
      pred_data_q   <= pred_data_d;
      spec_lock_q   <= spec_lock_d;
      recover_req_q <= recover_req_d;
      recover_pc_q  <= recover_pc_d;
      commit_q      <= commit_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_data   = pred_data_q;
  assign spec_lock   = spec_lock_q;
  assign recover_req = recover_req_q;
  assign recover_pc  = recover_pc_q;
  assign commit      = commit_q;

`ifdef VP_STATS_EN
  // Counters advance on the same edge the corresponding output asserts.
  logic [31:0] stat_pred_q, stat_correct_q, stat_recover_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_q    <= '0;
      stat_correct_q <= '0;
      stat_recover_q <= '0;
    end else begin
      if (pred_valid_d)                    stat_pred_q    <= stat_pred_q + 32'd1;
      if (commit_d)                        stat_correct_q <= stat_correct_q + 32'd1;
      if (recover_req_d && !recover_req_q) stat_recover_q <= stat_recover_q + 32'd1;
    end
  end

  assign stat_pred    = stat_pred_q;
  assign stat_correct = stat_correct_q;
  assign stat_recover = stat_recover_q;
`endif

endmodule

// File: tb/tb_vp_controller.sv
// -----------------------------------------------------------------------------
// tb_vp_controller
// Directed bench for vp_controller. A transaction-level model of the
// predictor (plain arrays for the table, a mode variable for the outstanding
// load) produces the expected outputs for every cycle; literal expectations
// pin the model and the table contents at the interesting points.
// -----------------------------------------------------------------------------
module tb_vp_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vp_allow, ld_miss, dc_resp_valid, squash, recover_ack;
  logic [31:0] ld_pc, dc_resp_data;
  logic        pred_valid, spec_lock, recover_req, commit;
  logic [31:0] pred_data, recover_pc;
`ifdef VP_STATS_EN
  logic [31:0] stat_pred, stat_correct, stat_recover;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vp_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vp_allow      (vp_allow),
    .ld_miss       (ld_miss),
    .ld_pc         (ld_pc),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_data  (dc_resp_data),
    .squash        (squash),
    .recover_ack   (recover_ack),
    .pred_valid    (pred_valid),
    .pred_data     (pred_data),
    .spec_lock     (spec_lock),
    .recover_req   (recover_req),
    .recover_pc    (recover_pc),
    .commit        (commit)
`ifdef VP_STATS_EN
    ,
    .stat_pred     (stat_pred),
    .stat_correct  (stat_correct),
    .stat_recover  (stat_recover)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 no load outstanding, 1 waiting on fill, 2 speculating, 3 recovering
  int          m_mode;
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_value [64];
  int          m_conf  [64];
  logic [31:0] m_pend_pc, m_pred_val;
  logic        e_pred_valid, e_spec_lock, e_recover_req, e_commit;
  logic [31:0] e_pred_data, e_recover_pc;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction
  function automatic int m_tg(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_conf[i]  = 0;
    end
    e_pred_valid = 0; e_pred_data = 0; e_spec_lock = 0;
    e_recover_req = 0; e_recover_pc = 0; e_commit = 0;
  endtask

  task automatic model_train(input logic [31:0] pc, input logic [31:0] data);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tg(pc)) begin
      if (m_value[i] == data) m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
      else begin m_value[i] = data; m_conf[i] = 0; end
    end else begin
      m_valid[i] = 1; m_tag[i] = m_tg(pc); m_value[i] = data; m_conf[i] = 0;
    end
  endtask

  task automatic model_step();
    int i;
    e_pred_valid = 0;
    e_commit     = 0;
    if (m_mode == 0) begin
      if (ld_miss) begin
        m_pend_pc = ld_pc;
        i = m_idx(ld_pc);
        if (vp_allow && m_valid[i] && m_tag[i] == m_tg(ld_pc) && m_conf[i] >= 2) begin
          m_pred_val   = m_value[i];
          e_pred_valid = 1; e_pred_data = m_value[i]; e_spec_lock = 1;
          m_mode = 2;
        end else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (squash) m_mode = 0;
      else if (dc_resp_valid) begin
        model_train(m_pend_pc, dc_resp_data);
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (squash) begin
        e_spec_lock = 0; m_mode = 0;
      end else if (dc_resp_valid) begin
        if (dc_resp_data == m_pred_val) begin
          e_commit = 1; e_spec_lock = 0; m_mode = 0;
        end else begin
          e_recover_req = 1; e_recover_pc = m_pend_pc; m_mode = 3;
        end
        model_train(m_pend_pc, dc_resp_data);
      end
    end else begin
      if (recover_ack) begin
        e_recover_req = 0; e_spec_lock = 0; m_mode = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge rst_n) model_reset();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("pred_valid", {31'b0, pred_valid}, {31'b0, e_pred_valid});
    check("spec_lock", {31'b0, spec_lock}, {31'b0, e_spec_lock});
    check("recover_req", {31'b0, recover_req}, {31'b0, e_recover_req});
    check("commit", {31'b0, commit}, {31'b0, e_commit});
    if (e_pred_valid) check("pred_data", pred_data, e_pred_data);
    if (e_recover_req) check("recover_pc", recover_pc, e_recover_pc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] pc);
    ld_miss = 1; ld_pc = pc;
    tick();
    ld_miss = 0;
  endtask

  task automatic do_resp(input logic [31:0] data);
    dc_resp_valid = 1; dc_resp_data = data;
    tick();
    dc_resp_valid = 0;
  endtask

  task automatic unpredicted_load(input logic [31:0] pc, input logic [31:0] data);
    do_miss(pc);
    tick();
    do_resp(data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 0; vp_allow = 1; ld_miss = 0; ld_pc = 0;
    dc_resp_valid = 0; dc_resp_data = 0; squash = 0; recover_ack = 0;
    repeat (3) tick();
    check("reset_spec_lock", {31'b0, spec_lock}, 32'd0);
    check("reset_recover_req", {31'b0, recover_req}, 32'd0);
    rst_n = 1;
    tick();

    // Cold miss: no prediction, entry allocated with conf 0.
    unpredicted_load(32'h400, 32'h1234);
    check("cold_valid", {31'b0, dut.u_table.valid_q[0]}, 32'd1);
    check("cold_value", dut.u_table.value_q[0], 32'h1234);
    check("cold_tag", {24'b0, dut.u_table.tag_q[0]}, 32'h04);
    check("cold_conf", {30'b0, dut.u_table.conf_q[0]}, 32'd0);

    // Train to threshold.
    unpredicted_load(32'h400, 32'h1234);
    unpredicted_load(32'h400, 32'h1234);
    check("train_conf2", {30'b0, dut.u_table.conf_q[0]}, 32'd2);

    // Predict, verify correct.
    do_miss(32'h400);
    check("pred_pulse", {31'b0, pred_valid}, 32'd1);
    check("pred_value", pred_data, 32'h1234);
    check("pred_lock", {31'b0, spec_lock}, 32'd1);
    do_resp(32'h1234);
    check("commit_pulse", {31'b0, commit}, 32'd1);
    check("commit_unlock", {31'b0, spec_lock}, 32'd0);
    check("commit_conf3", {30'b0, dut.u_table.conf_q[0]}, 32'd3);

    // Mispredict: recovery held until ack.
    do_miss(32'h400);
    do_resp(32'h5678);
    check("recover_req", {31'b0, recover_req}, 32'd1);
    check("recover_pc", recover_pc, 32'h400);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("recover_hold", {31'b0, recover_req & spec_lock}, 32'd1);
    end
    recover_ack = 1;
    tick();
    recover_ack = 0;
    check("ack_drop_req", {31'b0, recover_req}, 32'd0);
    check("ack_drop_lock", {31'b0, spec_lock}, 32'd0);
    check("mispred_value", dut.u_table.value_q[0], 32'h5678);
    check("mispred_conf", {30'b0, dut.u_table.conf_q[0]}, 32'd0);

    // Squash coincident with fill in SPEC: table untouched.
    unpredicted_load(32'h400, 32'h5678);
    unpredicted_load(32'h400, 32'h5678);
    do_miss(32'h400);
    squash = 1; dc_resp_valid = 1; dc_resp_data = 32'h9999;
    tick();
    squash = 0; dc_resp_valid = 0;
    check("squash_unlock", {31'b0, spec_lock}, 32'd0);
    check("squash_value", dut.u_table.value_q[0], 32'h5678);
    check("squash_conf", {30'b0, dut.u_table.conf_q[0]}, 32'd2);

    // Miss to a different PC while speculating is ignored.
    do_miss(32'h400);
    do_miss(32'h800);
    do_resp(32'h5678);
    check("b2b_commit", {31'b0, commit}, 32'd1);
    check("b2b_tag", {24'b0, dut.u_table.tag_q[0]}, 32'h04);
    check("b2b_conf3", {30'b0, dut.u_table.conf_q[0]}, 32'd3);

    // vp_allow low: WAIT path only, table still trains (conf saturates).
    vp_allow = 0;
    do_miss(32'h400);
    check("noallow_pred", {31'b0, pred_valid}, 32'd0);
    tick();
    do_resp(32'h5678);
    vp_allow = 1;
    check("noallow_conf_sat", {30'b0, dut.u_table.conf_q[0]}, 32'd3);

    // Tag conflict on the same index reallocates.
    unpredicted_load(32'h800, 32'hABCD);
    check("realloc_tag", {24'b0, dut.u_table.tag_q[0]}, 32'h08);
    check("realloc_value", dut.u_table.value_q[0], 32'hABCD);
    check("realloc_conf", {30'b0, dut.u_table.conf_q[0]}, 32'd0);

    // ld_miss and response together in IDLE: the response is dropped.
    ld_miss = 1; ld_pc = 32'h404; dc_resp_valid = 1; dc_resp_data = 32'h1111;
    tick();
    ld_miss = 0; dc_resp_valid = 0;
    check("same_cycle_no_train", {31'b0, dut.u_table.valid_q[1]}, 32'd0);
    tick();
    do_resp(32'h2222);
    check("same_cycle_late_train", dut.u_table.value_q[1], 32'h2222);

    // Async reset while recovering.
    unpredicted_load(32'h408, 32'h77);
    unpredicted_load(32'h408, 32'h77);
    unpredicted_load(32'h408, 32'h77);
    do_miss(32'h408);
    do_resp(32'h88);
    check("pre_reset_recover", {31'b0, recover_req}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_req", {31'b0, recover_req}, 32'd0);
    check("async_lock", {31'b0, spec_lock}, 32'd0);
    check("async_valid2", {31'b0, dut.u_table.valid_q[2]}, 32'd0);
    check("async_valid0", {31'b0, dut.u_table.valid_q[0]}, 32'd0);
    tick();
    rst_n = 1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
